// File: rtl/stream_packet_arbiter.sv
// rtl/stream_packet_arbiter.sv - packet-level round-robin arbiter for serial bit streams
// Optional locked-packet idle timeout enabled by defining STREAM_ARB_TIMEOUT_EN.
module stream_packet_arbiter #(
  parameter int N_SRC       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC-1:0]         src_sop,
  input  logic [N_SRC-1:0]         src_eop,
  input  logic [N_SRC-1:0]         src_data,
  output logic [N_SRC-1:0]         src_ready,
  input  logic                     dst_ready,
  output logic                     dst_valid,
  output logic                     dst_sop,
  output logic                     dst_eop,
  output logic                     dst_data,
  output logic [$clog2(N_SRC)-1:0] gnt_idx,
  output logic                     busy,
  output logic                     orphan_drop,
  output logic                     err_timeout
);

  localparam int IW = $clog2(N_SRC);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt;
  logic [IW-1:0]    gnt_nxt;
  logic [IW-1:0]    winner;
  logic [N_SRC-1:0] req;
  logic             found;
  logic             locked;
  logic             accept;
  logic             to;

  assign req     = src_valid & src_sop;
  assign locked  = reset_n && (state == S_LOCK);
  assign gnt_nxt = (gnt == IW'(N_SRC - 1)) ? '0 : gnt + 1'b1;
  assign accept  = locked && src_valid[gnt] && dst_ready && !to;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req[(int'(ptr) + k) % N_SRC]) begin
        winner = IW'((int'(ptr) + k) % N_SRC);
        found  = 1'b1;
      end
    end
  end

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;

  assign to = locked && (cnt == CW'(TIMEOUT_CYC));

  // Held at zero in IDLE, so entering LOCK always starts a fresh count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == S_IDLE || accept || to) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign to = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else if (state == S_IDLE) begin
      if (found) begin
        gnt   <= winner;
        state <= S_LOCK;
      end
    end else if (to || (accept && src_eop[gnt])) begin
      state <= S_IDLE;
      ptr   <= gnt_nxt;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    src_ready   = '0;
    dst_valid   = 1'b0;
    dst_sop     = 1'b0;
    dst_eop     = 1'b0;
    dst_data    = 1'b0;
    orphan_drop = 1'b0;
    err_timeout = 1'b0;
    busy        = locked;
    gnt_idx     = locked ? gnt : '0;
    if (reset_n) begin
      if (state == S_IDLE) begin
        src_ready   = src_valid & ~src_sop;
        orphan_drop = |(src_valid & ~src_sop);
      end else begin
        dst_valid      = src_valid[gnt] & ~to;
        dst_sop        = src_sop[gnt];
        dst_eop        = src_eop[gnt];
        dst_data       = src_data[gnt];
        src_ready[gnt] = dst_ready | to;
        err_timeout    = to;
      end
    end
  end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// tb/tb_stream_packet_arbiter.sv - directed self-checking bench for stream_packet_arbiter
module tb_stream_packet_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] src_valid;
  logic [3:0] src_sop;
  logic [3:0] src_eop;
  logic [3:0] src_data;
  logic [3:0] src_ready;
  logic       dst_ready;
  logic       dst_valid;
  logic       dst_sop;
  logic       dst_eop;
  logic       dst_data;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       orphan_drop;
  logic       err_timeout;

  int n_cmp;
  int n_bad;

  stream_packet_arbiter #(.N_SRC(4), .TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_valid   (src_valid),
    .src_sop     (src_sop),
    .src_eop     (src_eop),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .dst_ready   (dst_ready),
    .dst_valid   (dst_valid),
    .dst_sop     (dst_sop),
    .dst_eop     (dst_eop),
    .dst_data    (dst_data),
    .gnt_idx     (gnt_idx),
    .busy        (busy),
    .orphan_drop (orphan_drop),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic s, input logic e, input logic d);
    src_valid[i] = v;
    src_sop[i]   = s;
    src_eop[i]   = e;
    src_data[i]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] rx_data;
    logic [4:0] rx_sop;
    logic [4:0] rx_eop;
    int         rx_cnt;
    int         b;
    logic       rdy;
    logic [4:0] pat;

    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    src_valid = '0;
    src_sop   = '0;
    src_eop   = '0;
    src_data  = '0;
    dst_ready = 1'b1;
    step();
    step();
    #1;
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_idx, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_orphan", orphan_drop, 0);
    reset_n = 1'b1;
    step();

    // src0 three-beat packet 1,1,0
    drive(0, 1, 1, 0, 1);
    #1;
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_ready", src_ready, 4'b0000);
    step();
    #1;
    chk("t2_gnt", gnt_idx, 0);
    chk("t2_busy", busy, 1);
    chk("t2_b0_sop", dst_sop, 1);
    chk("t2_b0_data", dst_data, 1);
    chk("t2_ready", src_ready, 4'b0001);
    step();
    drive(0, 1, 0, 0, 1);
    #1;
    chk("t2_b1_sop", dst_sop, 0);
    chk("t2_b1_data", dst_data, 1);
    step();
    drive(0, 1, 0, 1, 0);
    #1;
    chk("t2_b2_valid", dst_valid, 1);
    chk("t2_b2_eop", dst_eop, 1);
    chk("t2_b2_data", dst_data, 0);
    step();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("t2_end_busy", busy, 0);
    chk("t2_end_valid", dst_valid, 0);

    // reset mid-packet while src0 is locked
    drive(0, 1, 1, 0, 1);
    step();
    step();
    drive(0, 1, 0, 0, 0);
    #1;
    chk("t1_locked", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t1_rst_valid", dst_valid, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_ready", src_ready, 0);
    chk("t1_rst_gnt", gnt_idx, 0);
    step();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1);
    #1;
    chk("t1_rel_busy", busy, 0);
    step();
    #1;
    chk("t1_gnt", gnt_idx, 1);
    chk("t1_sop", dst_sop, 1);
    chk("t1_eop", dst_eop, 1);
    chk("t1_ready", src_ready, 4'b0010);
    step();
    drive(1, 0, 0, 0, 0);
    #1;
    chk("t1_end_busy", busy, 0);

    // ptr=2: src0 and src2 request together -> src2, then src0
    drive(0, 1, 1, 1, 0);
    drive(2, 1, 1, 1, 1);
    step();
    #1;
    chk("t3a_gnt", gnt_idx, 2);
    chk("t3a_ready", src_ready, 4'b0100);
    chk("t3a_data", dst_data, 1);
    step();
    drive(2, 0, 0, 0, 0);
    #1;
    chk("t3a_gap_busy", busy, 0);
    chk("t3a_gap_ready", src_ready, 4'b0000);
    step();
    #1;
    chk("t3b_gnt", gnt_idx, 0);
    chk("t3b_data", dst_data, 0);
    chk("t3b_ready", src_ready, 4'b0001);
    step();
    drive(0, 0, 0, 0, 0);
    // ptr=1: src0 and src1 together -> src1, then src0
    drive(0, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1);
    step();
    #1;
    chk("t3c_gnt", gnt_idx, 1);
    step();
    drive(1, 0, 0, 0, 0);
    step();
    #1;
    chk("t3d_gnt", gnt_idx, 0);
    step();
    drive(0, 0, 0, 0, 0);

    // src2 five-beat packet 1,0,1,1,0 with 3 cycles of backpressure
    pat = 5'b10110;
    drive(2, 1, 1, 0, pat[4]);
    step();
    rx_data = '0;
    rx_sop  = '0;
    rx_eop  = '0;
    rx_cnt  = 0;
    b       = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      rdy = !(cyc >= 2 && cyc <= 4);
      drive(2, 1, (b == 0), (b == 4), pat[4 - b]);
      dst_ready = rdy;
      #1;
      if (!rdy) chk("t4_bp_ready", src_ready[2], 0);
      if (dst_valid && dst_ready) begin
        rx_data = {rx_data[3:0], dst_data};
        rx_sop  = {rx_sop[3:0], dst_sop};
        rx_eop  = {rx_eop[3:0], dst_eop};
        rx_cnt++;
      end
      step();
      if (rdy) b++;
    end
    drive(2, 0, 0, 0, 0);
    dst_ready = 1'b1;
    #1;
    chk("t4_count", rx_cnt, 5);
    chk("t4_data", rx_data, 5'b10110);
    chk("t4_sop", rx_sop, 5'b10000);
    chk("t4_eop", rx_eop, 5'b00001);
    chk("t4_end_busy", busy, 0);

    // orphan beat on src3 in IDLE
    drive(3, 1, 0, 0, 1);
    #1;
    chk("t5_ready", src_ready, 4'b1000);
    chk("t5_orphan", orphan_drop, 1);
    chk("t5_valid", dst_valid, 0);
    chk("t5_err", err_timeout, 0);
    step();
    #1;
    chk("t5_no_grant", busy, 0);
    drive(3, 0, 0, 0, 0);
    #1;
    chk("t5_orphan_clr", orphan_drop, 0);

`ifdef STREAM_ARB_TIMEOUT_EN
    // ptr=3: src1 SOP accepted, then 4 idle cycles -> timeout
    drive(1, 1, 1, 0, 1);
    step();
    #1;
    chk("t6_gnt", gnt_idx, 1);
    step();
    drive(1, 0, 0, 0, 0);
    #1;
    chk("t6_no_err", err_timeout, 0);
    step();
    step();
    step();
    step();
    #1;
    chk("t6_err", err_timeout, 1);
    chk("t6_flush_ready", src_ready, 4'b0010);
    chk("t6_valid", dst_valid, 0);
    step();
    drive(1, 1, 1, 1, 0);
    drive(2, 1, 1, 1, 1);
    #1;
    chk("t6_err_clr", err_timeout, 0);
    chk("t6_idle", busy, 0);
    step();
    #1;
    chk("t6_next_gnt", gnt_idx, 2);
    step();
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
